// File: rtl/bsg_manycore_decode_pkg.sv
// Shared op codes, FSM states and returning-packet flag layout for the manycore
// packet decode responder.
package bsg_manycore_decode_pkg;

    localparam logic [1:0] e_op_load    = 2'b00;
    localparam logic [1:0] e_op_store   = 2'b01;
    localparam logic [1:0] e_op_swap_aq = 2'b10;
    localparam logic [1:0] e_op_swap_rl = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_RDATA,
        SWAP_WR,
        RESP
    } state_e;

    // Flag fields of the returning packet; data and src coordinates travel alongside.
    typedef struct packed {
        logic is_store;
        logic err;
    } ret_flags_s;

    // Both swap flavours share one atomic read-old/write-new sequence.
    function automatic logic is_swap(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/bsg_manycore_decode_stats.sv
// Bank of saturating event counters for the decode responder; instantiated only
// when BSG_MANYCORE_DECODE_STATS_EN is defined.
module bsg_manycore_decode_stats #(
    parameter int els_p   = 4,
    parameter int width_p = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [els_p-1:0]                inc_i,
    output logic [els_p-1:0][width_p-1:0]   count_o
);

    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_ctr
            logic [width_p-1:0] count_q;
            logic [width_p-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (inc_i[gi] && (count_q != '1)) begin
                    count_d = count_q + width_p'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign count_o[gi] = count_q;
        end
    endgenerate

endmodule

// File: rtl/bsg_manycore_pkt_decode_responder.sv
// Services one remote load/store/swap at a time against tile-local SRAM and returns
// data or a store credit to the source tile. Optional counters: BSG_MANYCORE_DECODE_STATS_EN.
module bsg_manycore_pkt_decode_responder
    import bsg_manycore_decode_pkg::*;
#(
    parameter int x_cord_width_p = -1,
    parameter int y_cord_width_p = -1,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = -1,
    parameter int mem_els_p      = 1024,
    localparam int mask_width_lp     = data_width_p >> 3,
    localparam int mem_addr_width_lp = $clog2(mem_els_p),
    localparam int packet_width_lp   = 2 + mask_width_lp + addr_width_p + data_width_p
                                       + 2 * (x_cord_width_p + y_cord_width_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          pkt_v_i,
    input  logic [packet_width_lp-1:0]    pkt_i,
    output logic                          pkt_yumi_o,
    input  logic [x_cord_width_p-1:0]     my_x_i,
    input  logic [y_cord_width_p-1:0]     my_y_i,
    output logic                          mem_v_o,
    output logic                          mem_w_o,
    output logic [mem_addr_width_lp-1:0]  mem_addr_o,
    output logic [data_width_p-1:0]       mem_data_o,
    output logic [mask_width_lp-1:0]      mem_mask_o,
    input  logic                          mem_yumi_i,
    input  logic [data_width_p-1:0]       mem_data_i,
    output logic                          ret_v_o,
    input  logic                          ret_ready_i,
    output logic [data_width_p-1:0]       ret_data_o,
    output logic [x_cord_width_p-1:0]     ret_x_o,
    output logic [y_cord_width_p-1:0]     ret_y_o,
    output logic                          ret_is_store_o,
    output logic                          ret_err_o
`ifdef BSG_MANYCORE_DECODE_STATS_EN
    ,
    output logic [31:0]                   stat_load_o,
    output logic [31:0]                   stat_store_o,
    output logic [31:0]                   stat_swap_o,
    output logic [31:0]                   stat_err_o
`endif
);

    // Same field layout as the codebase packet-declaration macro.
    typedef struct packed {
        logic [1:0]                 op;
        logic [mask_width_lp-1:0]   op_ex;
        logic [addr_width_p-1:0]    addr;
        logic [data_width_p-1:0]    payload;
        logic [x_cord_width_p-1:0]  src_x;
        logic [y_cord_width_p-1:0]  src_y;
        logic [x_cord_width_p-1:0]  x_cord;
        logic [y_cord_width_p-1:0]  y_cord;
    } packet_s;

    state_e                     state_q, state_d;
    packet_s                    pkt_in, pkt_q, pkt_d;
    logic [data_width_p-1:0]    data_q, data_d;
    ret_flags_s                 ret_flags_q, ret_flags_d;
    logic                       consume;
    logic                       req_err;

    assign pkt_in  = pkt_i;
    assign consume = (state_q == IDLE) && pkt_v_i;
    // Range check sees every address bit, not just the ones that reach the SRAM.
    assign req_err = (pkt_in.x_cord != my_x_i) || (pkt_in.y_cord != my_y_i)
                     || (64'(pkt_in.addr) >= 64'(mem_els_p));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pkt_v_i) state_d = req_err ? RESP : MEM_REQ;
            MEM_REQ:   if (mem_yumi_i) state_d = (pkt_q.op == e_op_store) ? RESP : MEM_RDATA;
            MEM_RDATA: state_d = is_swap(pkt_q.op) ? SWAP_WR : RESP;
            SWAP_WR:   if (mem_yumi_i) state_d = RESP;
            RESP:      if (ret_ready_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt_yumi_o = 1'b0;
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = pkt_q.addr[mem_addr_width_lp-1:0];
        mem_data_o = pkt_q.payload;
        mem_mask_o = '1;
        ret_v_o    = 1'b0;
        case (state_q)
            IDLE:    pkt_yumi_o = pkt_v_i;
            MEM_REQ: begin
                mem_v_o = 1'b1;
                if (pkt_q.op == e_op_store) begin
                    mem_w_o    = 1'b1;
                    mem_mask_o = pkt_q.op_ex;
                end
            end
            SWAP_WR: begin
                mem_v_o = 1'b1;
                mem_w_o = 1'b1;
            end
            RESP:    ret_v_o = 1'b1;
            default: ;
        endcase
    end

    // Data is cleared on consume so stores and rejected packets return zero.
    always_comb begin
        pkt_d       = pkt_q;
        data_d      = data_q;
        ret_flags_d = ret_flags_q;
        if (consume) begin
            pkt_d                = pkt_in;
            data_d               = '0;
            ret_flags_d.err      = req_err;
            ret_flags_d.is_store = !req_err && (pkt_in.op == e_op_store);
        end
        if (state_q == MEM_RDATA) begin
            data_d = mem_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pkt_q       <= '0;
            data_q      <= '0;
            ret_flags_q <= '0;
        end else begin
            pkt_q       <= pkt_d;
            data_q      <= data_d;
            ret_flags_q <= ret_flags_d;
        end
    end

    assign ret_data_o     = data_q;
    assign ret_x_o        = pkt_q.src_x;
    assign ret_y_o        = pkt_q.src_y;
    assign ret_is_store_o = ret_v_o && ret_flags_q.is_store;
    assign ret_err_o      = ret_v_o && ret_flags_q.err;

`ifdef BSG_MANYCORE_DECODE_STATS_EN
    logic             ret_done;
    logic             ret_ok;
    logic [3:0]       stat_inc;
    logic [3:0][31:0] stat_count;

    assign ret_done = ret_v_o && ret_ready_i;
    assign ret_ok   = ret_done && !ret_flags_q.err;
    assign stat_inc = {ret_done && ret_flags_q.err,
                       ret_ok && is_swap(pkt_q.op),
                       ret_ok && (pkt_q.op == e_op_store),
                       ret_ok && (pkt_q.op == e_op_load)};

    bsg_manycore_decode_stats #(
        .els_p   (4),
        .width_p (32)
    ) stats (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (stat_inc),
        .count_o (stat_count)
    );

    assign stat_load_o  = stat_count[0];
    assign stat_store_o = stat_count[1];
    assign stat_swap_o  = stat_count[2];
    assign stat_err_o   = stat_count[3];
`endif

endmodule

// File: tb/tb_bsg_manycore_pkt_decode_responder.sv
// Self-checking bench for the manycore packet decode responder: directed vector table,
// stall/reset sequences and randomized traffic against a word-level memory model.
module tb_bsg_manycore_pkt_decode_responder;

    localparam int XW = 4, YW = 4, DW = 32, AW = 12, ELS = 1024, MW = DW >> 3;
    localparam int PW = 2 + MW + AW + DW + 2 * (XW + YW);
    localparam logic [1:0] OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_SWAP_AQ = 2'b10, OP_SWAP_RL = 2'b11;
    localparam logic [XW-1:0] MY_X = 4'd3;
    localparam logic [YW-1:0] MY_Y = 4'd2;

    typedef struct packed {
        logic [1:0]    op;
        logic [MW-1:0] op_ex;
        logic [AW-1:0] addr;
        logic [DW-1:0] payload;
        logic [XW-1:0] src_x;
        logic [YW-1:0] src_y;
        logic [XW-1:0] x_cord;
        logic [YW-1:0] y_cord;
    } pkt_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          store;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        int            lat;
        int            acc;
    } res_t;

    typedef struct {
        logic [1:0]    op;
        logic [MW-1:0] op_ex;
        logic [AW-1:0] addr;
        logic [DW-1:0] payload;
        bit            bad_x;
        bit            bad_y;
        logic [DW-1:0] exp_data;
        bit            exp_err;
        bit            exp_store;
        int            exp_acc;
        int            exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic pkt_v_i = 1'b0;
    logic [PW-1:0] pkt_i = '0;
    logic pkt_yumi_o;
    logic mem_v_o, mem_w_o;
    logic [9:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [MW-1:0] mem_mask_o;
    logic mem_yumi_i = 1'b1;
    logic [DW-1:0] mem_data_i;
    logic ret_v_o;
    logic ret_ready_i = 1'b1;
    logic [DW-1:0] ret_data_o;
    logic [XW-1:0] ret_x_o;
    logic [YW-1:0] ret_y_o;
    logic ret_is_store_o, ret_err_o;
`ifdef BSG_MANYCORE_DECODE_STATS_EN
    logic [31:0] stat_load_o, stat_store_o, stat_swap_o, stat_err_o;
`endif

    int n_checks = 0, n_fail = 0, cyc = 0;
    int mem_acc_cnt = 0, mem_wr_cnt = 0;
    int st_load = 0, st_store = 0, st_swap = 0, st_err = 0;
    bit stall_en = 1'b0;
    bit mem_init_done = 1'b0;
    logic [DW-1:0] sram [ELS];
    logic [DW-1:0] sram_rdata = '0;
    logic [DW-1:0] ref_mem [ELS];
    vec_t vecs [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bsg_manycore_pkt_decode_responder #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .mem_els_p(ELS)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .pkt_v_i(pkt_v_i), .pkt_i(pkt_i),
        .pkt_yumi_o(pkt_yumi_o), .my_x_i(MY_X), .my_y_i(MY_Y),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_yumi_i(mem_yumi_i),
        .mem_data_i(mem_data_i), .ret_v_o(ret_v_o), .ret_ready_i(ret_ready_i),
        .ret_data_o(ret_data_o), .ret_x_o(ret_x_o), .ret_y_o(ret_y_o),
        .ret_is_store_o(ret_is_store_o), .ret_err_o(ret_err_o)
`ifdef BSG_MANYCORE_DECODE_STATS_EN
        , .stat_load_o(stat_load_o), .stat_store_o(stat_store_o),
        .stat_swap_o(stat_swap_o), .stat_err_o(stat_err_o)
`endif
    );

    // SRAM model: read data appears the cycle after an accepted read, noise otherwise.
    always @(posedge clk) begin
        if (reset_i && !mem_init_done) begin
            for (int i = 0; i < ELS; i++) sram[i] <= '0;
            mem_init_done <= 1'b1;
        end
        if (mem_v_o && mem_yumi_i) begin
            mem_acc_cnt++;
            if (mem_w_o) begin
                mem_wr_cnt++;
                for (int b = 0; b < MW; b++)
                    if (mem_mask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
                sram_rdata <= $urandom();
            end else begin
                sram_rdata <= sram[mem_addr_o];
            end
        end else begin
            sram_rdata <= $urandom();
        end
    end
    assign mem_data_i = sram_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (stall_en) begin
            mem_yumi_i  = 1'($urandom_range(0, 1));
            ret_ready_i = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic pkt_t mk(input logic [1:0] op, input logic [MW-1:0] op_ex,
                                input logic [AW-1:0] addr, input logic [DW-1:0] payload,
                                input bit bad_x, input bit bad_y);
        pkt_t p;
        p.op = op; p.op_ex = op_ex; p.addr = addr; p.payload = payload;
        p.src_x = 4'($urandom()); p.src_y = 4'($urandom());
        p.x_cord = bad_x ? 4'(MY_X + 4'd1) : MY_X;
        p.y_cord = bad_y ? 4'(MY_Y + 4'd5) : MY_Y;
        return p;
    endfunction

    // Word-level reference: what each request must return and do to memory.
    task automatic ref_apply(input pkt_t p, output res_t e);
        int a;
        a = int'(p.addr);
        e.data = '0; e.err = 1'b0; e.store = 1'b0; e.x = p.src_x; e.y = p.src_y;
        if (p.x_cord != MY_X || p.y_cord != MY_Y || a >= ELS) begin
            e.err = 1'b1; e.acc = 0; e.lat = 1; st_err++;
        end else if (p.op == OP_LOAD) begin
            e.data = ref_mem[a]; e.acc = 1; e.lat = 3; st_load++;
        end else if (p.op == OP_STORE) begin
            for (int b = 0; b < MW; b++)
                if (p.op_ex[b]) ref_mem[a][8*b +: 8] = p.payload[8*b +: 8];
            e.store = 1'b1; e.acc = 1; e.lat = 2; st_store++;
        end else begin
            e.data = ref_mem[a]; ref_mem[a] = p.payload; e.acc = 2; e.lat = 4; st_swap++;
        end
    endtask

    task automatic wait_ret(input int c, output res_t r);
        bit seen, done;
        seen = 1'b0; done = 1'b0;
        r.data = '0; r.err = 1'b0; r.store = 1'b0; r.x = '0; r.y = '0; r.lat = -1; r.acc = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (ret_v_o && !seen) begin seen = 1'b1; r.lat = cyc - c; end
            if (ret_v_o && ret_ready_i) begin
                r.data = ret_data_o; r.err = ret_err_o; r.store = ret_is_store_o;
                r.x = ret_x_o; r.y = ret_y_o; done = 1'b1;
            end else begin
                tick();
            end
        end
        if (!done) check("ret_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_txn(input pkt_t p, output res_t r);
        int c, acc0;
        bit got;
        got = 1'b0;
        acc0 = mem_acc_cnt;
        tick();
        pkt_v_i = 1'b1; pkt_i = p;
        for (int k = 0; k < 200 && !got; k++) begin
            #1;
            if (pkt_yumi_o) got = 1'b1;
            else tick();
        end
        if (!got) check("yumi_timeout", 64'(0), 64'(1));
        c = cyc;
        tick();
        pkt_v_i = 1'b0;
        wait_ret(c, r);
        r.acc = mem_acc_cnt - acc0;
        $display("txn op=%0d addr=%0d err=%0b store=%0b data=%h lat=%0d acc=%0d",
                 p.op, p.addr, r.err, r.store, r.data, r.lat, r.acc);
    endtask

    task automatic cmp_res(input string t, input res_t g, input res_t e, input bit chk_lat);
        check({t, ".data"},  64'(g.data),  64'(e.data));
        check({t, ".err"},   64'(g.err),   64'(e.err));
        check({t, ".store"}, 64'(g.store), 64'(e.store));
        check({t, ".x"},     64'(g.x),     64'(e.x));
        check({t, ".y"},     64'(g.y),     64'(e.y));
        check({t, ".acc"},   64'(g.acc),   64'(e.acc));
        if (chk_lat) check({t, ".lat"}, 64'(g.lat), 64'(e.lat));
    endtask

    initial begin
        pkt_t p, p2;
        res_t g, e, scratch;
        int c, wr0;

        vecs[0]  = '{OP_STORE,   4'b0011, 12'd5,    32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1, 2};
        vecs[1]  = '{OP_LOAD,    4'b0000, 12'd5,    32'h0,        1'b0, 1'b0, 32'h0000BEEF, 1'b0, 1'b0, 1, 3};
        vecs[2]  = '{OP_STORE,   4'b1111, 12'd7,    32'h11,       1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1, 2};
        vecs[3]  = '{OP_SWAP_AQ, 4'b0000, 12'd7,    32'h22,       1'b0, 1'b0, 32'h11,       1'b0, 1'b0, 2, 4};
        vecs[4]  = '{OP_LOAD,    4'b0000, 12'd7,    32'h0,        1'b0, 1'b0, 32'h22,       1'b0, 1'b0, 1, 3};
        vecs[5]  = '{OP_LOAD,    4'b0000, 12'd5,    32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 0, 1};
        vecs[6]  = '{OP_STORE,   4'b1111, 12'd1024, 32'h5,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 0, 1};
        vecs[7]  = '{OP_LOAD,    4'b0000, 12'd0,    32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1, 3};
        vecs[8]  = '{OP_SWAP_RL, 4'b0000, 12'd1023, 32'hA5A5,     1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2, 4};
        vecs[9]  = '{OP_LOAD,    4'b0000, 12'd1023, 32'h0,        1'b0, 1'b0, 32'hA5A5,     1'b0, 1'b0, 1, 3};
        vecs[10] = '{OP_STORE,   4'b1111, 12'd5,    32'h77,       1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 0, 1};
        vecs[11] = '{OP_LOAD,    4'b0000, 12'd4095, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 0, 1};

        for (int i = 0; i < ELS; i++) ref_mem[i] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("rst.pkt_yumi", 64'(pkt_yumi_o), 64'(0));
        check("rst.mem_v",    64'(mem_v_o),    64'(0));
        check("rst.ret_v",    64'(ret_v_o),    64'(0));
        check("rst.ret_err",  64'(ret_err_o),  64'(0));
        check("rst.ret_store",64'(ret_is_store_o), 64'(0));
        check("rst.ret_data", 64'(ret_data_o), 64'(0));

        // Directed vectors with ideal memory and return path.
        for (int i = 0; i < 12; i++) begin
            p = mk(vecs[i].op, vecs[i].op_ex, vecs[i].addr, vecs[i].payload, vecs[i].bad_x, vecs[i].bad_y);
            ref_apply(p, scratch);
            run_txn(p, g);
            e.data = vecs[i].exp_data; e.err = vecs[i].exp_err; e.store = vecs[i].exp_store;
            e.x = p.src_x; e.y = p.src_y; e.acc = vecs[i].exp_acc; e.lat = vecs[i].exp_lat;
            cmp_res($sformatf("vec%0d", i), g, e, 1'b1);
        end

        // Memory stalls 3 cycles, return path stalls 2; a second packet waits throughout.
        p  = mk(OP_STORE, 4'b1111, 12'd9, 32'h12345678, 1'b0, 1'b0);
        p2 = mk(OP_LOAD,  4'b0000, 12'd9, 32'h0,        1'b0, 1'b0);
        ref_apply(p, scratch);
        ref_apply(p2, scratch);
        tick();
        pkt_v_i = 1'b1; pkt_i = p; mem_yumi_i = 1'b0;
        #1 check("stall.consume", 64'(pkt_yumi_o), 64'(1));
        tick();
        pkt_i = p2; ret_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall.mem_v",    64'(mem_v_o),    64'(1));
            check("stall.mem_w",    64'(mem_w_o),    64'(1));
            check("stall.mem_addr", 64'(mem_addr_o), 64'(9));
            check("stall.mem_data", 64'(mem_data_o), 64'(32'h12345678));
            check("stall.mem_mask", 64'(mem_mask_o), 64'(4'hF));
            check("stall.yumi",     64'(pkt_yumi_o), 64'(0));
            tick();
        end
        mem_yumi_i = 1'b1;
        #1 check("stall.mem_v_last", 64'(mem_v_o), 64'(1));
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            check("stall.ret_v",     64'(ret_v_o),        64'(1));
            check("stall.ret_store", 64'(ret_is_store_o), 64'(1));
            check("stall.ret_x",     64'(ret_x_o),        64'(p.src_x));
            check("stall.ret_y",     64'(ret_y_o),        64'(p.src_y));
            check("stall.ret_yumi",  64'(pkt_yumi_o),     64'(0));
            tick();
        end
        ret_ready_i = 1'b1;
        #1;
        check("stall.ret_v_hs", 64'(ret_v_o),    64'(1));
        check("stall.hs_yumi",  64'(pkt_yumi_o), 64'(0));
        tick();
        #1 check("stall.next_consume", 64'(pkt_yumi_o), 64'(1));
        c = cyc;
        tick();
        pkt_v_i = 1'b0;
        wait_ret(c, g);
        check("stall.load_data", 64'(g.data), 64'(32'h12345678));
        check("stall.load_lat",  64'(g.lat),  64'(3));

        // Reset while a swap sits in MEM_RDATA: no write-back and no response.
        p = mk(OP_STORE, 4'b1111, 12'd11, 32'h33, 1'b0, 1'b0);
        ref_apply(p, scratch);
        run_txn(p, g);
        p = mk(OP_SWAP_AQ, 4'b0000, 12'd11, 32'h77, 1'b0, 1'b0);
        tick();
        pkt_v_i = 1'b1; pkt_i = p;
        #1 check("rstswap.consume", 64'(pkt_yumi_o), 64'(1));
        tick();
        pkt_v_i = 1'b0;
        #1 check("rstswap.mem_read", 64'({mem_v_o, mem_w_o}), 64'(2'b10));
        tick();
        reset_i = 1'b1;
        wr0 = mem_wr_cnt;
        #1 check("rstswap.rdata_idle", 64'(mem_v_o), 64'(0));
        tick();
        reset_i = 1'b0;
        st_load = 0; st_store = 0; st_swap = 0; st_err = 0;
        #1;
        check("rstswap.ret_v",    64'(ret_v_o),    64'(0));
        check("rstswap.mem_v",    64'(mem_v_o),    64'(0));
        check("rstswap.ret_data", 64'(ret_data_o), 64'(0));
`ifdef BSG_MANYCORE_DECODE_STATS_EN
        check("rstswap.stat_store", 64'(stat_store_o), 64'(0));
`endif
        for (int k = 0; k < 4; k++) begin
            tick();
            #1 check("rstswap.quiet", 64'({ret_v_o, mem_v_o}), 64'(0));
        end
        check("rstswap.no_write", 64'(mem_wr_cnt), 64'(wr0));
        p = mk(OP_LOAD, 4'b0000, 12'd11, 32'h0, 1'b0, 1'b0);
        ref_apply(p, e);
        run_txn(p, g);
        cmp_res("rstswap.reload", g, e, 1'b1);
        check("rstswap.old_value", 64'(g.data), 64'(32'h33));

        // Randomized traffic with random memory and return-path back-pressure.
        stall_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [1:0] op;
            logic [AW-1:0] a;
            int r;
            bit bx, by;
            op = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 19);
            if (r < 16) a = AW'(r);
            else if (r == 16) a = 12'd1023;
            else a = AW'($urandom_range(1024, 4095));
            bx = ($urandom_range(0, 14) == 0);
            by = ($urandom_range(0, 14) == 0);
            p = mk(op, 4'($urandom()), a, $urandom(), bx, by);
            ref_apply(p, e);
            run_txn(p, g);
            cmp_res($sformatf("rnd%0d", i), g, e, 1'b0);
        end
        stall_en = 1'b0;
        tick();
        mem_yumi_i = 1'b1; ret_ready_i = 1'b1;

`ifdef BSG_MANYCORE_DECODE_STATS_EN
        tick();
        #1;
        check("stat.load",  64'(stat_load_o),  64'(st_load));
        check("stat.store", 64'(stat_store_o), 64'(st_store));
        check("stat.swap",  64'(stat_swap_o),  64'(st_swap));
        check("stat.err",   64'(stat_err_o),   64'(st_err));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_pkt_decode_responder.md
Name: bsg_manycore_pkt_decode_responder

Overview:
Endpoint-side counterpart of the manycore packet encoder. Accepts one inbound remote packet at a time, checks its destination coordinates and address, and runs the load, store or swap against tile-local synchronous memory. It then emits a single returning packet (data or store credit) toward the source tile. Sits between the tile's network-receive FIFO and the local DMEM/SRAM port.

Parameters:
x_cord_width_p, -1 (must set), coordinate width in X
y_cord_width_p, -1 (must set), coordinate width in Y
data_width_p, 32, payload/word width; mask width = data_width_p>>3
addr_width_p, -1 (must set), packet word-address width
mem_els_p, 1024, local memory words; mem_addr_width_lp = clog2(mem_els_p)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
pkt_v_i  in  1  inbound packet valid
pkt_i  in  packet_width_lp  manycore packet struct (op, op_ex, addr, payload, src_x/y, x/y_cord)
pkt_yumi_o  out  1  packet consumed this cycle
my_x_i / my_y_i  in  x/y_cord_width_p  this tile's coordinates
mem_v_o  out  1  memory request valid
mem_w_o  out  1  1 = write
mem_addr_o  out  mem_addr_width_lp  word address
mem_data_o  out  data_width_p  write data
mem_mask_o  out  data_width_p>>3  byte write mask
mem_yumi_i  in  1  memory accepted request
mem_data_i  in  data_width_p  read data, valid exactly 1 cycle after accepted read
ret_v_o  out  1  returning packet valid
ret_ready_i  in  1  returning path ready
ret_data_o  out  data_width_p  load/old-swap data; 0 for store/error
ret_x_o / ret_y_o  out  x/y_cord_width_p  = captured src_x/src_y
ret_is_store_o  out  1  store credit
ret_err_o  out  1  request rejected

Behaviour:
- Reset: state IDLE; pkt_yumi_o, mem_v_o, ret_v_o, ret_err_o, ret_is_store_o = 0; data registers = 0. A reset in any state abandons the in-flight request with no response.
- Op codes are package constants: load 2'b00, store 2'b01, swap_aq 2'b10, swap_rl 2'b11. Both swaps behave identically here: atomic read-old/write-new of the full word.
- IDLE: pkt_yumi_o = pkt_v_i. On consume, register the packet.
  - Error if x_cord != my_x_i, y_cord != my_y_i, or addr >= mem_els_p. On error go to RESP with ret_err_o = 1 and perform no memory access.
  - Otherwise go to MEM_REQ.
- MEM_REQ: mem_v_o = 1, held stable until mem_yumi_i.
  - Load/swap: mem_w_o = 0, then MEM_RDATA.
  - Store: mem_w_o = 1, mask = op_ex, data = payload, then RESP.
- MEM_RDATA: latch mem_data_i. Load goes to RESP; swap goes to SWAP_WR.
- SWAP_WR: write payload with mask all-ones, held until mem_yumi_i, then RESP.
- RESP: ret_v_o = 1, outputs stable until ret_ready_i, then IDLE.
- No new packet is accepted outside IDLE, so pkt_yumi_o is 0 in every other state.
- Latency from consume cycle C (memory and return path always ready):
  - store: ret_v_o at C+2
  - load: C+3
  - swap: C+4
  - error: C+1
- Throughput: one packet in flight. The earliest next consume is the cycle after the ret handshake.
- Address: mem_addr_o = addr[mem_addr_width_lp-1:0]. The range check uses the full addr_width_p bits, zero-extended compare.

Optional Feature:
BSG_MANYCORE_DECODE_STATS_EN: adds outputs stat_load_o, stat_store_o, stat_swap_o, stat_err_o (32-bit each). Each is a saturating counter, incremented on the ret handshake of its class and cleared by reset. Without the macro these ports and counters do not exist.

Decomposition:
- Shared package bsg_manycore_decode_pkg holds:
  - op code constants
  - state enum {IDLE, MEM_REQ, MEM_RDATA, SWAP_WR, RESP}
  - returning-packet field layout
- The packet struct comes from the existing codebase packet-declaration macro.
- One natural sub-module: bsg_manycore_decode_stats, the saturating counter bank, instantiated only under the macro.

Test Plan:
1. Store addr=5, payload=0xDEADBEEF, op_ex=4'b0011 -> mem write addr 5, mask 0011. ret_v_o at C+2 with ret_is_store_o=1, ret_x/y = src.
2. Load addr=5 after test 1 with a memory model -> ret_data_o=0x0000BEEF at C+3.
3. swap_aq addr=7 (mem holds 0x11), payload 0x22 -> read then write. ret_data_o=0x11 at C+4; a following load returns 0x22.
4. Packet x_cord=my_x+1, then addr=mem_els_p -> each gives ret_err_o=1 at C+1 with no mem_v_o.
5. Hold mem_yumi_i=0 for 3 cycles and ret_ready_i=0 for 2 cycles -> mem request and ret outputs stay stable; pkt_yumi_o stays 0 throughout.
6. Assert reset_i in MEM_RDATA of a swap -> IDLE next cycle, no write issued, no ret_v_o.
